// File: rtl/reg_demux_pipe.sv
// ---------------------------------------------------------------------------
// reg_demux_pipe
//
// Purpose:
//   Two-stage register demultiplexer. A write request (channel index + data)
//   is accepted into a stage-1 pending register. On the next un-held edge it
//   is written into the selected output channel register, which pulses a
//   one-cycle strobe and increments a modulo-256 write counter.
//
// Configuration macro:
//   DEMUX_ZERO_UNSEL_EN - when defined, every drain also zeroes all
//                         non-selected channels (exclusive decoder). When it
//                         is undefined, non-selected channels hold their value.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   write request present
//   in_ready     out  request can be accepted this cycle
//   reg_select   in   [SEL_WIDTH]            destination channel
//   reg_data     in   [DATA_WIDTH]           write data
//   hold         in   stall stage-2 update
//   clear        in   synchronous clear of channels and pending request
//   out_data     out  [NUM_OUT*DATA_WIDTH]   channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_strobe   out  [NUM_OUT]              one-hot pulse on the channel just written
//   busy         out  a request is pending in stage 1
//   write_count  out  [8]                    completed writes, modulo 256
// ---------------------------------------------------------------------------
module reg_demux_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_OUT    = 4,
  localparam int SEL_WIDTH = $clog2(NUM_OUT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_WIDTH-1:0]          reg_select,
  input  logic [DATA_WIDTH-1:0]         reg_data,
  input  logic                          hold,
  input  logic                          clear,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]            out_strobe,
  output logic                          busy,
  output logic [7:0]                    write_count
);

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [SEL_WIDTH-1:0]          sel_q, sel_d;
  logic [DATA_WIDTH-1:0]         data_q, data_d;
  logic [NUM_OUT*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [NUM_OUT-1:0]            out_strobe_q, out_strobe_d;
  logic [7:0]                    write_count_q, write_count_d;

  logic accept;
  logic drain;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      // Clear wins over everything, including a same-edge accept.
      state_d = EMPTY;
    end else if (accept) begin
      // Covers EMPTY->PENDING and drain-with-accept refill.
      state_d = PENDING;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // An empty stage 1 can always take a request; a full one only when it
    // is about to drain (hold low).
    in_ready = (state_q == EMPTY) || !hold;
    busy     = (state_q == PENDING);
  end

  assign accept = in_valid && in_ready;
  assign drain  = (state_q == PENDING) && !hold && !clear;

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    sel_d         = sel_q;
    data_d        = data_q;
    out_data_d    = out_data_q;
    out_strobe_d  = '0;
    write_count_d = write_count_q;

    if (accept) begin
      sel_d  = reg_select;
      data_d = reg_data;
    end

    if (clear) begin
      out_data_d = '0;
    end else if (drain) begin
      write_count_d = write_count_q + 8'd1;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (sel_q == SEL_WIDTH'(k)) begin
          out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = data_q;
          out_strobe_d[k]                        = 1'b1;
        end else begin
`ifdef DEMUX_ZERO_UNSEL_EN
          out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
`else
          out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = out_data_q[k*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q         <= '0;
      data_q        <= '0;
      out_data_q    <= '0;
      out_strobe_q  <= '0;
      write_count_q <= '0;
    end else begin
      sel_q         <= sel_d;
      data_q        <= data_d;
      out_data_q    <= out_data_d;
      out_strobe_q  <= out_strobe_d;
      write_count_q <= write_count_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_strobe  = out_strobe_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_reg_demux_pipe.sv
// ---------------------------------------------------------------------------
// tb_reg_demux_pipe
//
// Directed self-checking bench for reg_demux_pipe (DATA_WIDTH=16, NUM_OUT=4).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_reg_demux_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  reg_select;
  logic [15:0] reg_data;
  logic        hold;
  logic        clear;
  logic [63:0] out_data;
  logic [3:0]  out_strobe;
  logic        busy;
  logic [7:0]  write_count;

  int checks   = 0;
  int failures = 0;

  // Reference model of the channel contents and write counter.
  logic [15:0] exp_ch [4];
  int          exp_count;

  reg_demux_pipe #(.DATA_WIDTH(16), .NUM_OUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reg_select (reg_select),
    .reg_data   (reg_data),
    .hold       (hold),
    .clear      (clear),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .busy       (busy),
    .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_drain(input int s, input logic [15:0] d);
    for (int k = 0; k < 4; k++) begin
      if (k == s) exp_ch[k] = d;
`ifdef DEMUX_ZERO_UNSEL_EN
      else exp_ch[k] = 16'h0000;
`endif
    end
    exp_count = (exp_count + 1) % 256;
  endfunction

  function automatic void model_zero();
    for (int k = 0; k < 4; k++) exp_ch[k] = 16'h0000;
  endfunction

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; reg_select = '0; reg_data = '0;
    hold = 1'b0; clear = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_zero();
    exp_count = 0;
    checks++; if (out_data !== 64'h0) begin failures++;
      $display("FAIL reset_out_data got=%h exp=%h", out_data, 64'h0); end
    checks++; if (out_strobe !== 4'b0000) begin failures++;
      $display("FAIL reset_strobe got=%b exp=0000", out_strobe); end
    checks++; if (write_count !== 8'd0) begin failures++;
      $display("FAIL reset_count got=%0d exp=0", write_count); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    step(); step();
    rst_n = 1'b1;
    step();
    $display("test_reset done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single();
    in_valid = 1'b1; reg_select = 2'd2; reg_data = 16'hA5A5;
    step();                       // accept edge
    in_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || out_strobe !== 4'b0000) begin failures++;
      $display("FAIL single_pending got busy=%b strobe=%b exp busy=1 strobe=0000", busy, out_strobe); end
    step();                       // drain edge
    model_drain(2, 16'hA5A5);
    checks++; if (out_strobe !== 4'b0100) begin failures++;
      $display("FAIL single_strobe got=%b exp=0100", out_strobe); end
    checks++; if (out_data !== 64'h0000_A5A5_0000_0000) begin failures++;
      $display("FAIL single_out_data got=%h exp=0000a5a500000000", out_data); end
    checks++; if (write_count !== 8'd1 || busy !== 1'b0) begin failures++;
      $display("FAIL single_count got count=%0d busy=%b exp count=1 busy=0", write_count, busy); end
    step();
    checks++; if (out_strobe !== 4'b0000) begin failures++;
      $display("FAIL single_strobe_pulse got=%b exp=0000", out_strobe); end
    $display("test_single done: ch2=%h count=%0d", out_data[47:32], write_count);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [3:0] exp_strobe;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; reg_select = 2'(i); reg_data = 16'(i + 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i > 0) begin
        model_drain(i - 1, 16'(i));
        exp_strobe = 4'b0001 << (i - 1);
        checks++; if (out_strobe !== exp_strobe) begin failures++;
          $display("FAIL b2b_strobe%0d got=%b exp=%b", i - 1, out_strobe, exp_strobe); end
        checks++; if (in_ready !== 1'b1) begin failures++;
          $display("FAIL b2b_ready%0d got=%b exp=1", i - 1, in_ready); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data[k*16 +: 16] !== exp_ch[k]) begin failures++;
        $display("FAIL b2b_ch%0d got=%h exp=%h", k, out_data[k*16 +: 16], exp_ch[k]); end
    end
    checks++; if (write_count !== 8'd5) begin failures++;
      $display("FAIL b2b_count got=%0d exp=5", write_count); end
    $display("test_back_to_back done: out=%h count=%0d", out_data, write_count);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_same_channel();
    in_valid = 1'b1; reg_select = 2'd0; reg_data = 16'h0007;
    step();
    reg_data = 16'h0008;
    step();
    model_drain(0, 16'h0007);
    checks++; if (out_strobe !== 4'b0001 || out_data[15:0] !== 16'h0007) begin failures++;
      $display("FAIL same_first got strobe=%b ch0=%h exp strobe=0001 ch0=0007", out_strobe, out_data[15:0]); end
    in_valid = 1'b0;
    step();
    model_drain(0, 16'h0008);
    checks++; if (out_strobe !== 4'b0001 || out_data[15:0] !== 16'h0008) begin failures++;
      $display("FAIL same_second got strobe=%b ch0=%h exp strobe=0001 ch0=0008", out_strobe, out_data[15:0]); end
    checks++; if (write_count !== 8'(exp_count)) begin failures++;
      $display("FAIL same_count got=%0d exp=%0d", write_count, exp_count); end
    step();
    $display("test_same_channel done: count=%0d", write_count);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_hold();
    hold = 1'b1; in_valid = 1'b1; reg_select = 2'd1; reg_data = 16'h1234;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL hold_ready_empty got=%b exp=1", in_ready); end
    step();                       // accept while held (stage 1 was empty)
    // A competing request during hold must be refused.
    reg_select = 2'd3; reg_data = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_strobe !== 4'b0000) begin failures++;
        $display("FAIL hold_cycle%0d got ready=%b busy=%b strobe=%b exp ready=0 busy=1 strobe=0000",
                 c, in_ready, busy, out_strobe); end
      step();
    end
    in_valid = 1'b0; hold = 1'b0;
    step();                       // drain
    model_drain(1, 16'h1234);
    checks++; if (out_strobe !== 4'b0010 || busy !== 1'b0) begin failures++;
      $display("FAIL hold_drain got strobe=%b busy=%b exp strobe=0010 busy=0", out_strobe, busy); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data[k*16 +: 16] !== exp_ch[k]) begin failures++;
        $display("FAIL hold_ch%0d got=%h exp=%h", k, out_data[k*16 +: 16], exp_ch[k]); end
    end
    step();
    checks++; if (out_strobe !== 4'b0000 || busy !== 1'b0) begin failures++;
      $display("FAIL hold_after got strobe=%b busy=%b exp strobe=0000 busy=0", out_strobe, busy); end
    $display("test_hold done: ch1=%h", out_data[31:16]);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_clear();
    in_valid = 1'b1; reg_select = 2'd0; reg_data = 16'h0009;
    step();                       // request pending
    reg_select = 2'd1; reg_data = 16'hAAAA; clear = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL clear_ready got=%b exp=1", in_ready); end
    step();                       // clear edge, same-edge accept discarded
    clear = 1'b0; in_valid = 1'b0;
    model_zero();
    checks++; if (out_data !== 64'h0 || busy !== 1'b0 || out_strobe !== 4'b0000) begin failures++;
      $display("FAIL clear_state got out=%h busy=%b strobe=%b exp out=0 busy=0 strobe=0000",
               out_data, busy, out_strobe); end
    checks++; if (write_count !== 8'(exp_count)) begin failures++;
      $display("FAIL clear_count got=%0d exp=%0d", write_count, exp_count); end
    step();
    checks++; if (out_strobe !== 4'b0000 || out_data !== 64'h0) begin failures++;
      $display("FAIL clear_after got strobe=%b out=%h exp strobe=0000 out=0", out_strobe, out_data); end
    $display("test_clear done: count=%0d", write_count);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    in_valid = 1'b1; reg_select = 2'd3; reg_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_zero();
    exp_count = 0;
    checks++; if (busy !== 1'b0 || write_count !== 8'd0 || out_data !== 64'h0) begin failures++;
      $display("FAIL rstmid_async got busy=%b count=%0d out=%h exp busy=0 count=0 out=0",
               busy, write_count, out_data); end
    step();
    rst_n = 1'b1;
    step(); step();
    checks++; if (out_strobe !== 4'b0000 || out_data[63:48] !== 16'h0000) begin failures++;
      $display("FAIL rstmid_lost got strobe=%b ch3=%h exp strobe=0000 ch3=0000", out_strobe, out_data[63:48]); end
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; reg_select = 2'(i % 4); reg_data = 16'(i);
      step();
      if (i > 0) model_drain((i - 1) % 4, 16'(i - 1));
    end
    in_valid = 1'b0;
    step();
    model_drain(299 % 4, 16'd299);
    checks++; if (write_count !== 8'd44) begin failures++;
      $display("FAIL rstmid_wrap got=%0d exp=44", write_count); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data[k*16 +: 16] !== exp_ch[k]) begin failures++;
        $display("FAIL rstmid_ch%0d got=%h exp=%h", k, out_data[k*16 +: 16], exp_ch[k]); end
    end
    $display("test_reset_mid done: count=%0d out=%h", write_count, out_data);
  endtask

`ifdef DEMUX_ZERO_UNSEL_EN
  // -------------------------------------------------------------------------
  task automatic test_zero_unsel();
    in_valid = 1'b1; reg_select = 2'd0; reg_data = 16'h0001;
    step();
    reg_select = 2'd1;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_data[15:0] !== 16'h0000 || out_data[31:16] !== 16'h0001) begin failures++;
      $display("FAIL zero_unsel got ch0=%h ch1=%h exp ch0=0000 ch1=0001", out_data[15:0], out_data[31:16]); end
    $display("test_zero_unsel done: out=%h", out_data);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_same_channel();
    test_hold();
    test_clear();
    test_reset_mid();
`ifdef DEMUX_ZERO_UNSEL_EN
    test_zero_unsel();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
